// File: rtl/blend_sequencer.sv
// Per-pixel read-modify-write sequencer: captures one pixel, optionally fetches the
// background, samples the external blend datapath and issues the masked 16-bit write.
module blend_sequencer #(
   parameter int ADDR_W = 19,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_pixValid,
   output logic              o_pixReady,
   input  logic [9:0]        i_pixX,
   input  logic [8:0]        i_pixY,
   input  logic [7:0]        i_pixR,
   input  logic [7:0]        i_pixG,
   input  logic [7:0]        i_pixB,
   input  logic              i_pixSTP,
   input  logic              i_pixTransparent,
   input  logic              i_noblend,
   input  logic [1:0]        i_mode,
   input  logic              i_checkMask,
   input  logic              i_forceMask,
   output logic              o_rdReq,
   output logic [ADDR_W-1:0] o_rdAddr,
   input  logic              i_rdAck,
   input  logic              i_rdValid,
   input  logic [15:0]       i_rdData,
   output logic [4:0]        o_bgR,
   output logic [4:0]        o_bgG,
   output logic [4:0]        o_bgB,
   output logic [7:0]        o_pxR,
   output logic [7:0]        o_pxG,
   output logic [7:0]        o_pxB,
   output logic              o_pxSTP,
   output logic              o_pxTransparent,
   output logic              o_noblend,
   output logic [1:0]        o_mode,
   input  logic [7:0]        i_blR,
   input  logic [7:0]        i_blG,
   input  logic [7:0]        i_blB,
   output logic              o_wrReq,
   output logic [ADDR_W-1:0] o_wrAddr,
   output logic [15:0]       o_wrData,
   input  logic              i_wrAck,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_cntWritten,
   output logic [CNT_W-1:0]  o_cntSkipped
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_BLEND   = 3'd3;
   localparam logic [2:0] S_WR_REQ  = 3'd4;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0]        r_state;
   logic              r_pixReady, r_rdReq, r_wrReq, r_busy;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_pxR, r_pxG, r_pxB;
   logic              r_stp, r_transp, r_noblend, r_checkMask, r_forceMask;
   logic [1:0]        r_mode;
   logic [15:0]       r_bg;
   logic [15:0]       r_wrData;
   logic [CNT_W-1:0]  r_cntWritten, r_cntSkipped;

   logic [2:0]        w_next;
   logic [ADDR_W-1:0] w_pixAddr;
   logic              w_accept, w_discard, w_semi, w_needBg;
   logic              w_bgLoad, w_resLoad, w_incSkip, w_incWr;

   // Only the top five bits of each blended channel survive into VRAM
   function automatic logic [15:0] pack_wr(input logic m, input logic [7:0] b,
                                           input logic [7:0] g, input logic [7:0] r);
      pack_wr = {m, b[7:3], g[7:3], r[7:3]};
   endfunction

   // Next-state and event decode
   always_comb begin
      w_pixAddr = ADDR_W'({i_pixY, i_pixX});
      w_discard = i_pixTransparent & ~i_pixSTP;
      w_semi    = i_pixSTP & ~i_noblend;
      w_needBg  = ~w_discard & (w_semi | i_checkMask);
      w_accept  = 1'b0;
      w_bgLoad  = 1'b0;
      w_resLoad = 1'b0;
      w_incSkip = 1'b0;
      w_incWr   = 1'b0;
      w_next    = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_pixValid) begin
               w_accept = 1'b1;
               if (w_discard) begin
                  w_incSkip = 1'b1;
                  w_next    = S_IDLE;
               end else if (w_needBg) begin
                  w_next = S_RD_REQ;
               end else begin
                  w_next = S_BLEND;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RD_REQ: begin
            if (i_rdAck & i_rdValid) begin
               w_bgLoad = 1'b1;
               w_next   = S_BLEND;
            end else if (i_rdAck) begin
               w_next = S_RD_WAIT;
            end else begin
               w_next = S_RD_REQ;
            end
         end
         S_RD_WAIT: begin
            if (i_rdValid) begin
               w_bgLoad = 1'b1;
               w_next   = S_BLEND;
            end else begin
               w_next = S_RD_WAIT;
            end
         end
         S_BLEND: begin
            w_resLoad = 1'b1;
            if (r_checkMask & r_bg[15]) begin
               w_incSkip = 1'b1;
               w_next    = S_IDLE;
            end else begin
               w_next = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (i_wrAck) begin
               w_incWr = 1'b1;
               w_next  = S_IDLE;
            end else begin
               w_next = S_WR_REQ;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, registered handshake outputs, captured pixel, background, result and counters
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_pixReady   <= 1'b1;
         r_rdReq      <= 1'b0;
         r_wrReq      <= 1'b0;
         r_busy       <= 1'b0;
         r_addr       <= {ADDR_W{1'b0}};
         r_pxR        <= 8'h00;
         r_pxG        <= 8'h00;
         r_pxB        <= 8'h00;
         r_stp        <= 1'b0;
         r_transp     <= 1'b0;
         r_noblend    <= 1'b0;
         r_checkMask  <= 1'b0;
         r_forceMask  <= 1'b0;
         r_mode       <= 2'b00;
         r_bg         <= 16'h0000;
         r_wrData     <= 16'h0000;
         r_cntWritten <= {CNT_W{1'b0}};
         r_cntSkipped <= {CNT_W{1'b0}};
      end else begin
         r_state    <= w_next;
         r_pixReady <= (w_next == S_IDLE);
         r_rdReq    <= (w_next == S_RD_REQ);
         r_wrReq    <= (w_next == S_WR_REQ);
         r_busy     <= (w_next != S_IDLE);
         if (w_accept) begin
            r_addr      <= w_pixAddr;
            r_pxR       <= i_pixR;
            r_pxG       <= i_pixG;
            r_pxB       <= i_pixB;
            r_stp       <= i_pixSTP;
            r_transp    <= i_pixTransparent;
            r_noblend   <= i_noblend;
            r_checkMask <= i_checkMask;
            r_forceMask <= i_forceMask;
            r_mode      <= i_mode;
            r_bg        <= 16'h0000;
         end else if (w_bgLoad) begin
            r_bg <= i_rdData;
         end
         if (w_resLoad) begin
            r_wrData <= pack_wr(r_forceMask | r_stp, i_blB, i_blG, i_blR);
         end
         if (w_incSkip) begin
            r_cntSkipped <= r_cntSkipped + CNT_ONE;
         end
         if (w_incWr) begin
            r_cntWritten <= r_cntWritten + CNT_ONE;
         end
      end
   end

   assign o_pixReady      = r_pixReady;
   assign o_busy          = r_busy;
   assign o_rdReq         = r_rdReq;
   assign o_wrReq         = r_wrReq;
   assign o_rdAddr        = r_addr;
   assign o_wrAddr        = r_addr;
   assign o_wrData        = r_wrData;
   assign o_bgR           = r_bg[4:0];
   assign o_bgG           = r_bg[9:5];
   assign o_bgB           = r_bg[14:10];
   assign o_pxR           = r_pxR;
   assign o_pxG           = r_pxG;
   assign o_pxB           = r_pxB;
   assign o_pxSTP         = r_stp;
   assign o_pxTransparent = r_transp;
   assign o_noblend       = r_noblend;
   assign o_mode          = r_mode;
   assign o_cntWritten    = r_cntWritten;
   assign o_cntSkipped    = r_cntSkipped;

endmodule
